alu_cmd_sequencer: RTL

- Upstream feeder for the 8-register accumulator CPU.
- Buffers packed command words from a host or testbench through a valid/ready FIFO.
- Replays each command onto the CPU's data_in/opcode/cin/cout/load/ce pins with correct pacing:
  - load commands: back-to-back, one per cycle.
  - execute commands: a one-cycle ce pulse, then a hold-off while the CPU writes the ALU result to register 0.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/alu_cmd_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU command path: the packed
// command word layout and the sequencer state encoding.
package cpu_pkg;

  localparam int CMD_W    = 18;
  localparam int LOAD_BIT = 17;
  localparam int OPC_MSB  = 16;
  localparam int OPC_LSB  = 10;
  localparam int DATA_MSB = 9;
  localparam int DATA_LSB = 2;
  localparam int CIN_BIT  = 1;
  localparam int COUT_BIT = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Pushes are ignored when full and pops when empty; no write-through.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Replays buffered command words onto the accumulator CPU pins: loads issue
// back-to-back, executes pulse ce once and then hold off for EXEC_WAIT cycles.
module alu_cmd_sequencer
  import cpu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int EXEC_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd_word,
  input  logic             hold,
  output logic             ce,
  output logic             load,
  output logic [6:0]       opcode,
  output logic [7:0]       data_out,
  output logic             cin,
  output logic             cout,
  output logic             busy,
  output logic [7:0]       issue_cnt
);

  localparam int WAIT_W = (EXEC_WAIT < 2) ? 1 : $clog2(EXEC_WAIT + 1);

  logic [CMD_W-1:0]       w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_pop;

  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic [WAIT_W-1:0]      w_wait_nxt;

  logic                   r_ce;
  logic                   r_load;
  logic [6:0]             r_opcode;
  logic [7:0]             r_data;
  logic                   r_cin;
  logic                   r_cout;
  logic [7:0]             r_issue_cnt;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata (cmd_word),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_pop && !w_head[LOAD_BIT]) begin
          w_state_nxt = S_WAIT;
          w_wait_nxt  = WAIT_W'(EXEC_WAIT);
        end
      end
      S_WAIT: begin
        w_wait_nxt = r_wait_cnt - 1'b1;
        if (r_wait_cnt == WAIT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_wait_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Pop decision and status flags; the pop edge is also the issue edge.
  always_comb begin
    w_pop     = (r_state == S_IDLE) && !w_empty && !hold;
    cmd_ready = !w_full;
    busy      = (w_count != '0) || (r_state == S_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ce        <= 1'b0;
      r_load      <= 1'b0;
      r_opcode    <= '0;
      r_data      <= '0;
      r_cin       <= 1'b0;
      r_cout      <= 1'b0;
      r_issue_cnt <= '0;
    end else begin
      r_ce <= w_pop;
      if (w_pop) begin
        r_load      <= w_head[LOAD_BIT];
        r_opcode    <= w_head[OPC_MSB:OPC_LSB];
        r_data      <= w_head[DATA_MSB:DATA_LSB];
        r_cin       <= w_head[CIN_BIT];
        r_cout      <= w_head[COUT_BIT];
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
    end
  end

  assign ce        = r_ce;
  assign load      = r_load;
  assign opcode    = r_opcode;
  assign data_out  = r_data;
  assign cin       = r_cin;
  assign cout      = r_cout;
  assign issue_cnt = r_issue_cnt;

endmodule
